// File: rtl/wb_timer_multi_if.sv
// Wishbone slave bus bundle for wb_timer_multi.
//   wb_cyc_i/wb_stb_i/wb_we_i : cycle, strobe, write enable (master -> slave)
//   wb_sel_i                  : byte enables, writes only
//   wb_adr_i/wb_dat_i         : byte address / write data
//   wb_dat_o/wb_ack_o         : registered read data / acknowledge (slave -> master)
interface wb_timer_multi_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_timer_multi.sv
// Multi-channel Wishbone compare timer.
// NUM_CH independent channels share one prescaler; each channel counts prescaler
// ticks up to its COMPARE value, raises a W1C flag and either restarts (periodic)
// or stops (one-shot). irq_o is the registered OR of IE-enabled flags.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wb         : Wishbone slave bundle (wb_timer_multi_if.slave)
//   irq_o      : level interrupt, registered

// One timer channel: CTRL bits, COUNT, COMPARE and match flag.
module wb_timer_ch #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             ctrl_we_i,
  input  logic [2:0]       ctrl_wd_i,
  input  logic             cnt_we_i,
  input  logic [CNT_W-1:0] cnt_wd_i,
  input  logic             cmp_we_i,
  input  logic [CNT_W-1:0] cmp_wd_i,
  input  logic             start_i,
  input  logic             w1c_i,
  output logic             en_o,
  output logic             os_o,
  output logic             ie_o,
  output logic             flag_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cmp_o
);
  logic             en_q, en_d, os_q, os_d, ie_q, ie_d, flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cmp_q, cmp_d;

  // Ordering below encodes priority: later assignments win.
  always_comb begin
    en_d   = en_q;
    os_d   = os_q;
    ie_d   = ie_q;
    cnt_d  = cnt_q;
    cmp_d  = cmp_q;
    flag_d = flag_q & ~w1c_i;
    if (tick_i && en_q) begin
      if (cnt_q == cmp_q) begin
        flag_d = 1'b1;            // hw set beats a same-cycle W1C
        cnt_d  = '0;
        if (os_q) en_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (ctrl_we_i) {ie_d, os_d, en_d} = ctrl_wd_i;  // beats one-shot auto-clear
    if (start_i)   en_d  = 1'b1;
    if (cnt_we_i)  cnt_d = cnt_wd_i;                 // beats the tick
    if (cmp_we_i)  cmp_d = cmp_wd_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      os_q   <= 1'b0;
      ie_q   <= 1'b0;
      flag_q <= 1'b0;
      cnt_q  <= '0;
      cmp_q  <= '1;
    end else begin
      en_q   <= en_d;
      os_q   <= os_d;
      ie_q   <= ie_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
    end
  end

  assign en_o   = en_q;
  assign os_o   = os_q;
  assign ie_o   = ie_q;
  assign flag_o = flag_q;
  assign cnt_o  = cnt_q;
  assign cmp_o  = cmp_q;
endmodule

module wb_timer_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PSC_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_timer_multi_if.slave wb,
  output logic            irq_o
);
  // Replace the bytes of old_v selected by be with those of new_v.
  function automatic logic [31:0] bmerge(input logic [31:0] old_v,
                                         input logic [31:0] new_v,
                                         input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  logic                         ack_q, ack_d, irq_q, irq_d;
  logic [31:0]                  dat_q, dat_d, rd_mux;
  logic [PSC_W-1:0]             psc_q, psc_d, pcnt_q, pcnt_d;
  logic [31:0]                  adr, wmask;
  logic [3:0]                   sel;
  logic                         acc, wr, ch_win, psc_we, sts_we, start_we;
  logic                         any_en, tick;
  logic [NUM_CH-1:0]            en_a, os_a, ie_a, flag_a;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_a, cmp_a;
  logic                         unused_ok;

  assign adr    = wb.wb_adr_i;
  assign sel    = wb.wb_sel_i;
  // Accept only when no ACK is outstanding: one idle cycle between accesses.
  assign acc    = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr     = acc & wb.wb_we_i;
  assign ch_win = ~adr[7];
  // Write data with unselected bytes zeroed; used for bit-mask registers.
  assign wmask  = bmerge(32'h0, wb.wb_dat_i, sel);

  assign psc_we   = wr & (adr[7:2] == 6'h20) & (|sel);
  assign sts_we   = wr & (adr[7:2] == 6'h21);
  assign start_we = wr & (adr[7:2] == 6'h22);

  assign unused_ok = ^{adr[31:8], adr[1:0], wmask};

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic hit;
    assign hit = wr & ch_win & (adr[6:4] == 3'(n));
    wb_timer_ch #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_i    (tick),
      .ctrl_we_i (hit & (adr[3:2] == 2'd0) & sel[0]),
      .ctrl_wd_i (wmask[2:0]),
      .cnt_we_i  (hit & (adr[3:2] == 2'd1) & (|sel)),
      .cnt_wd_i  (CNT_W'(bmerge(32'(cnt_a[n]), wb.wb_dat_i, sel))),
      .cmp_we_i  (hit & (adr[3:2] == 2'd2) & (|sel)),
      .cmp_wd_i  (CNT_W'(bmerge(32'(cmp_a[n]), wb.wb_dat_i, sel))),
      .start_i   (start_we & wmask[n]),
      .w1c_i     (sts_we & wmask[n]),
      .en_o      (en_a[n]),
      .os_o      (os_a[n]),
      .ie_o      (ie_a[n]),
      .flag_o    (flag_a[n]),
      .cnt_o     (cnt_a[n]),
      .cmp_o     (cmp_a[n])
    );
  end

  // Shared prescaler, parked at 0 whenever every channel is disabled.
  assign any_en = |en_a;
  assign tick   = any_en & (pcnt_q == psc_q);

  always_comb begin
    psc_d  = psc_q;
    pcnt_d = pcnt_q;
    if (!any_en || tick) pcnt_d = '0;
    else                 pcnt_d = pcnt_q + 1'b1;
    if (psc_we) begin
      psc_d  = PSC_W'(bmerge(32'(psc_q), wb.wb_dat_i, sel));
      pcnt_d = '0;
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    if (ch_win) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (adr[6:4] == 3'(i)) begin
          case (adr[3:2])
            2'd0:    rd_mux = {29'd0, ie_a[i], os_a[i], en_a[i]};
            2'd1:    rd_mux = 32'(cnt_a[i]);
            2'd2:    rd_mux = 32'(cmp_a[i]);
            default: rd_mux = 32'h0;
          endcase
        end
      end
    end else begin
      case (adr[7:2])
        6'h20:   rd_mux = 32'(psc_q);
        6'h21:   rd_mux = 32'(flag_a);
        default: rd_mux = 32'h0;
      endcase
    end
  end

  assign ack_d = acc;
  assign dat_d = (acc && !wb.wb_we_i) ? rd_mux : 32'h0;
  assign irq_d = |(flag_a & ie_a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q  <= 1'b0;
      dat_q  <= 32'h0;
      irq_q  <= 1'b0;
      psc_q  <= '0;
      pcnt_q <= '0;
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      irq_q  <= irq_d;
      psc_q  <= psc_d;
      pcnt_q <= pcnt_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign irq_o       = irq_q;
endmodule

// File: tb/tb_wb_timer_multi.sv
// Self-checking bench for wb_timer_multi: directed scenarios followed by random
// bus traffic, all checked against a behavioural model of the register map.
module tb_wb_timer_multi;
  localparam int NCH = 4;

  logic gclk, grst_n, irq;
  wb_timer_multi_if wbi();

  wb_timer_multi #(.NUM_CH(NCH), .CNT_W(32), .PSC_W(16)) dut (
    .clk   (gclk),
    .rst_n (grst_n),
    .wb    (wbi),
    .irq_o (irq)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  bit [NCH-1:0][31:0] m_cnt, m_cmp;
  bit [NCH-1:0]       m_en, m_os, m_ie, m_flag;
  bit [31:0]          m_preg, m_pcnt, m_rdat;
  bit                 m_ack, m_irq;

  function automatic bit [31:0] merge(bit [31:0] o, bit [31:0] d, bit [3:0] s);
    bit [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic bit [31:0] ref_read(bit [31:0] a);
    int ch = int'(a[6:4]);
    if (!a[7]) begin
      if (ch < NCH) begin
        if (a[3:2] == 2'd0) return {29'd0, m_ie[ch], m_os[ch], m_en[ch]};
        if (a[3:2] == 2'd1) return m_cnt[ch];
        if (a[3:2] == 2'd2) return m_cmp[ch];
      end
      return 32'h0;
    end
    if (a[7:2] == 6'h20) return m_preg;
    if (a[7:2] == 6'h21) return 32'(m_flag);
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_cnt <= '0; m_cmp <= '1; m_en <= '0; m_os <= '0; m_ie <= '0; m_flag <= '0;
    m_preg <= 0; m_pcnt <= 0; m_rdat <= 0; m_ack <= 0; m_irq <= 0;
  endtask

  task automatic model_step();
    bit [NCH-1:0][31:0] cnt = m_cnt, cmp = m_cmp;
    bit [NCH-1:0] en = m_en, os = m_os, ie = m_ie, set = '0, w1c = '0;
    bit [31:0] pcnt, preg = m_preg, rd = 0, wv, a = wbi.wb_adr_i, d = wbi.wb_dat_i;
    bit [3:0] s = wbi.wb_sel_i;
    bit acc, any, tk;
    int ch = int'(a[6:4]);
    acc = wbi.wb_cyc_i && wbi.wb_stb_i && !m_ack;
    if (acc && !wbi.wb_we_i) rd = ref_read(a);
    any  = |m_en;
    tk   = any && (m_pcnt == m_preg);
    pcnt = (!any || tk) ? 0 : m_pcnt + 1;
    for (int i = 0; i < NCH; i++)
      if (tk && m_en[i]) begin
        if (m_cnt[i] == m_cmp[i]) begin
          set[i] = 1'b1; cnt[i] = 0;
          if (m_os[i]) en[i] = 1'b0;
        end else cnt[i] = m_cnt[i] + 1;
      end
    if (acc && wbi.wb_we_i) begin
      wv = merge(0, d, s);
      if (!a[7]) begin
        if (ch < NCH) begin
          if (a[3:2] == 2'd0 && s[0]) begin ie[ch] = wv[2]; os[ch] = wv[1]; en[ch] = wv[0]; end
          if (a[3:2] == 2'd1 && s != 0) cnt[ch] = merge(m_cnt[ch], d, s);
          if (a[3:2] == 2'd2 && s != 0) cmp[ch] = merge(m_cmp[ch], d, s);
        end
      end else if (a[7:2] == 6'h20 && s != 0) begin
        preg = merge(m_preg, d, s) & 32'h0000_FFFF; pcnt = 0;
      end else if (a[7:2] == 6'h21) w1c = wv[NCH-1:0];
      else if (a[7:2] == 6'h22) en = en | wv[NCH-1:0];
    end
    m_cnt <= cnt; m_cmp <= cmp; m_en <= en; m_os <= os; m_ie <= ie;
    m_flag <= (m_flag & ~w1c) | set;
    m_preg <= preg; m_pcnt <= pcnt; m_rdat <= rd; m_ack <= acc;
    m_irq <= |(m_flag & m_ie);
  endtask

  always @(posedge gclk or negedge grst_n)
    if (!grst_n) model_reset();
    else         model_step();

  always @(negedge gclk)
    if (chk_en) begin
      chk("irq", 32'(irq), 32'(m_irq));
      chk("ack", 32'(wbi.wb_ack_o), 32'(m_ack));
    end

  // ---------------- bus tasks ----------------
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    int n = 0;
    @(negedge gclk);
    wbi.wb_cyc_i = 1; wbi.wb_stb_i = 1; wbi.wb_we_i = 1;
    wbi.wb_adr_i = a; wbi.wb_dat_i = d; wbi.wb_sel_i = s;
    do begin @(negedge gclk); n++; end while (!wbi.wb_ack_o && n < 8);
    chk("wr_ack", 32'(wbi.wb_ack_o), 32'd1);
    wbi.wb_cyc_i = 0; wbi.wb_stb_i = 0; wbi.wb_we_i = 0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    int n = 0;
    @(negedge gclk);
    wbi.wb_cyc_i = 1; wbi.wb_stb_i = 1; wbi.wb_we_i = 0;
    wbi.wb_adr_i = a; wbi.wb_sel_i = 4'hF;
    do begin @(negedge gclk); n++; end while (!wbi.wb_ack_o && n < 8);
    chk("rd_ack", 32'(wbi.wb_ack_o), 32'd1);
    d = wbi.wb_dat_o;
    chk("rd_dat", d, m_rdat);
    wbi.wb_cyc_i = 0; wbi.wb_stb_i = 0;
  endtask

  task automatic wait_irq(input string tag, input int exp_lat);
    int lat = 0;
    while (!irq && lat < 100) begin @(negedge gclk); lat++; end
    chk(tag, lat, exp_lat);
  endtask

  logic [31:0] rd;
  logic [5:0]  acks;

  initial begin
    wbi.wb_cyc_i = 0; wbi.wb_stb_i = 0; wbi.wb_we_i = 0;
    wbi.wb_sel_i = 0; wbi.wb_adr_i = 0; wbi.wb_dat_i = 0;
    grst_n = 0;
    repeat (3) @(negedge gclk);
    grst_n = 1;
    chk_en = 1;

    // reset state
    chk("rst_irq", 32'(irq), 0);
    chk("rst_dat", wbi.wb_dat_o, 0);
    wb_read(32'h08, rd); chk("rst_cmp0", rd, 32'hFFFF_FFFF);
    wb_read(32'h04, rd); chk("rst_cnt0", rd, 0);
    wb_read(32'h80, rd); chk("rst_psc", rd, 0);
    wb_read(32'h84, rd); chk("rst_sts", rd, 0);

    // 1: periodic ch0, flag on 4th tick, irq one cycle later
    wb_write(32'h08, 3);
    wb_write(32'h80, 0);
    wb_write(32'h00, 5);
    wait_irq("t1_lat", 5);
    repeat (3) begin wb_read(32'h04, rd); end

    // 2: one-shot ch1, PRESCALER=4 -> flag after 15 cycles
    wb_write(32'h00, 0);
    wb_write(32'h84, 1);
    wb_write(32'h80, 4);
    wb_write(32'h18, 2);
    wb_write(32'h10, 7);
    wait_irq("t2_lat", 16);
    repeat (40) @(negedge gclk);
    wb_read(32'h14, rd); chk("t2_cnt1", rd, 0);
    wb_read(32'h10, rd); chk("t2_ctrl1", rd, 6);
    wb_read(32'h84, rd); chk("t2_sts", rd, 2);

    // 3: START both channels, W1C clears only flag0
    wb_write(32'h84, 3);
    wb_write(32'h80, 0);
    wb_write(32'h08, 1); wb_write(32'h18, 1);
    wb_write(32'h04, 0); wb_write(32'h14, 0);
    wb_write(32'h00, 4); wb_write(32'h10, 4);
    wb_write(32'h88, 3);
    wait_irq("t3_lat", 3);
    wb_read(32'h84, rd); chk("t3_sts_both", rd, 3);
    wb_read(32'h88, rd); chk("t3_start_rd", rd, 0);
    wb_write(32'h00, 4); wb_write(32'h10, 4);
    wb_write(32'h84, 1);
    wb_read(32'h84, rd); chk("t3_w1c", rd, 2);

    // 4: COUNT write on a tick; W1C colliding with flag set
    wb_write(32'h84, 3);
    wb_write(32'h08, 1000);
    wb_write(32'h04, 0);
    wb_write(32'h00, 1);
    wb_write(32'h04, 32'h100);
    wb_read(32'h04, rd); chk("t4_cnt", rd, 32'h101);
    wb_write(32'h08, 0);
    wb_write(32'h04, 0);
    wb_write(32'h84, 1);
    wb_read(32'h84, rd); chk("t4_w1c_set", rd & 32'h1, 1);

    // 5: byte enables, unmapped read, back-to-back strobes
    wb_write(32'h00, 0);
    wb_write(32'h04, 32'h1122_3344);
    wb_write(32'h04, 32'hAABB_CCDD, 4'b0010);
    wb_read(32'h04, rd); chk("t5_byte1", rd, 32'h1122_CC44);
    wb_read(32'hFC, rd); chk("t5_unmap", rd, 0);
    @(negedge gclk);
    wbi.wb_cyc_i = 1; wbi.wb_stb_i = 1; wbi.wb_we_i = 0; wbi.wb_adr_i = 32'h84;
    acks = 0;
    for (int i = 0; i < 6; i++) begin @(negedge gclk); acks = {acks[4:0], wbi.wb_ack_o}; end
    wbi.wb_cyc_i = 0; wbi.wb_stb_i = 0;
    chk("t5_b2b", 32'(acks), 32'b101010);

    // 6: async reset while running with irq high and an ACK pending
    wb_write(32'h84, 1);
    wb_write(32'h04, 0);
    wb_write(32'h00, 5);
    wait_irq("t6_lat", 2);
    chk("t6_pre_irq", 32'(irq), 1);
    @(negedge gclk);
    wbi.wb_cyc_i = 1; wbi.wb_stb_i = 1; wbi.wb_we_i = 0; wbi.wb_adr_i = 32'h04;
    @(negedge gclk);
    chk("t6_pre_ack", 32'(wbi.wb_ack_o), 1);
    #2 grst_n = 0;
    #1;
    chk("t6_irq_async", 32'(irq), 0);
    chk("t6_ack_async", 32'(wbi.wb_ack_o), 0);
    wbi.wb_cyc_i = 0; wbi.wb_stb_i = 0;
    repeat (2) @(negedge gclk);
    grst_n = 1;
    wb_read(32'h04, rd); chk("t6_cnt0", rd, 0);
    wb_read(32'h00, rd); chk("t6_ctrl0", rd, 0);
    repeat (20) @(negedge gclk);
    wb_read(32'h84, rd); chk("t6_sts", rd, 0);
    chk("t6_irq", 32'(irq), 0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      int kind = $urandom_range(0, 9);
      if (kind < 7) a = {24'd0, 1'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
      else          a = {24'd0, 4'h8, 2'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 9) == 0) a = 32'hFC;
      if (a[7] && a[3:2] == 2'd0) d = $urandom_range(0, 3);
      else if (!a[7] && a[3:2] != 2'd0 && $urandom_range(0, 7) != 0) d = $urandom_range(0, 12);
      else d = $urandom;
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 9) < 6) wb_write(a, d, s);
      else                          wb_read(a, rd);
      repeat ($urandom_range(0, 3)) @(negedge gclk);
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
